// File: rtl/spi_master_ram_if.sv
// SPI master that serialises one {cmd, wdata} frame to an SPI RAM slave and,
// for read-data frames, waits RD_WAIT cycles and then captures one byte from MISO.
module spi_master_ram_if #(
  parameter int unsigned RD_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEND = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RECV = 3'd3;
  localparam logic [2:0] S_END  = 3'd4;

  localparam logic [3:0] SEND_LAST = 4'd10;
  localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] RECV_LAST = 4'd7;

  logic [2:0] state;
  logic [3:0] cnt;
  logic [9:0] shreg;
  logic [1:0] cmd_q;
  logic [7:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      shreg   <= '0;
      cmd_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) begin
            shreg <= {cmd, wdata};
            cmd_q <= cmd;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          // First cycle repeats cmd[1] as the select bit, so shifting starts after it.
          if (cnt != '0)
            shreg <= {shreg[8:0], 1'b0};
          if (cnt == SEND_LAST) begin
            cnt   <= '0;
            state <= (cmd_q == 2'b11) ? S_WAIT : S_END;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_WAIT: begin
          if (cnt == WAIT_LAST) begin
            cnt   <= '0;
            state <= S_RECV;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_RECV: begin
          rdata_q <= {rdata_q[6:0], MISO};
          if (cnt == RECV_LAST) begin
            cnt   <= '0;
            state <= S_END;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_END: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from registered state so reset forces them at once.
  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_END);
    rd_valid = (state == S_END) && (cmd_q == 2'b11);
    SS_n     = !((state == S_SEND) || (state == S_WAIT) || (state == S_RECV));
    MOSI     = (state == S_SEND) && shreg[9];
    rdata    = rdata_q;
  end

endmodule

// File: tb/tb_spi_master_ram_if.sv
// Bench: three masters (RD_WAIT 2, 1, 15) each talking to a behavioural SPI RAM
// slave; frames are checked against a command-level reference model.
module tb_spi_master_ram_if;

  localparam int unsigned RDW [3] = '{2, 1, 15};

  logic       clk = 1'b0;
  logic [2:0] rst_v   = '1;
  logic [2:0] start_v = '0;
  logic [2:0] miso_v  = '0;
  logic [1:0] cmd_v   [3];
  logic [7:0] wdata_v [3];
  logic [2:0] busy_v, done_v, rd_valid_v, ss_n_v, mosi_v;
  logic [7:0] rdata_v [3];

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    spi_master_ram_if #(.RD_WAIT(RDW[g])) u_dut (
      .clk      (clk),
      .rst      (rst_v[g]),
      .start    (start_v[g]),
      .cmd      (cmd_v[g]),
      .wdata    (wdata_v[g]),
      .busy     (busy_v[g]),
      .done     (done_v[g]),
      .rdata    (rdata_v[g]),
      .rd_valid (rd_valid_v[g]),
      .SS_n     (ss_n_v[g]),
      .MOSI     (mosi_v[g]),
      .MISO     (miso_v[g])
    );
  end

  // Behavioural SPI RAM slave: collects 11 MOSI bits per frame, then serves a byte.
  int         scnt [3];
  logic [10:0] ssh [3];
  logic [1:0] scmd [3];
  logic [7:0] swa [3], sra [3];
  logic [7:0] sram [3][256];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ss_n_v[i]) begin
        scnt[i]   = 0;
        miso_v[i] = 1'b0;
      end else begin
        scnt[i] = scnt[i] + 1;
        if (scnt[i] <= 11) ssh[i] = {ssh[i][9:0], mosi_v[i]};
        if (scnt[i] == 11) begin
          scmd[i] = ssh[i][9:8];
          case (ssh[i][9:8])
            2'b00: swa[i] = ssh[i][7:0];
            2'b01: sram[i][swa[i]] = ssh[i][7:0];
            2'b10: sra[i] = ssh[i][7:0];
            default: ;
          endcase
        end
        miso_v[i] = 1'b0;
        if (scnt[i] > 11 && scmd[i] == 2'b11) begin
          int first;
          first = 12 + int'(RDW[i]);
          if (scnt[i] >= first && scnt[i] < first + 8)
            miso_v[i] = sram[i][sra[i]][7 - (scnt[i] - first)];
        end
      end
    end
  end

  // Command-level reference model
  logic [7:0] ref_ram [3][256];
  logic [7:0] ref_wa [3], ref_ra [3], ref_rd [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic run_frame(input int d, input logic [1:0] c, input logic [7:0] w);
    logic [10:0] mos;
    int lat, lows;
    logic dv;
    logic [7:0] rd;
    mos = '0; lat = 0; lows = 0; dv = 1'b0; rd = '0;
    start_v[d] = 1'b1; cmd_v[d] = c; wdata_v[d] = w;
    @(posedge clk); #1;
    start_v[d] = 1'b0; cmd_v[d] = 2'($urandom); wdata_v[d] = 8'($urandom);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_after_accept", busy_v[d], 1);
      if (k <= 11) begin
        mos = {mos[9:0], mosi_v[d]};
        if (!ss_n_v[d]) lows++;
      end
      if (done_v[d]) begin
        lat = k; dv = rd_valid_v[d]; rd = rdata_v[d];
        check("ss_n_at_done", ss_n_v[d], 1);
        break;
      end
    end
    case (c)
      2'b00: ref_wa[d] = w;
      2'b01: ref_ram[d][ref_wa[d]] = w;
      2'b10: ref_ra[d] = w;
      default: ref_rd[d] = ref_ram[d][ref_ra[d]];
    endcase
    check("mosi_seq", mos, {c[1], c, w});
    check("ss_low_send", lows, 11);
    check("latency", lat, (c == 2'b11) ? 20 + int'(RDW[d]) : 12);
    check("rd_valid", dv, (c == 2'b11));
    check("rdata", rd, ref_rd[d]);
    @(negedge clk);
    check("idle_busy", busy_v[d], 0);
    check("idle_ss_mosi", {ss_n_v[d], mosi_v[d], done_v[d]}, 3'b100);
  endtask

  initial begin
    logic [7:0] a, v;
    int ndone;
    logic [25:0] ss_seen, ss_exp, dn_seen, dn_exp;
    for (int i = 0; i < 3; i++) begin
      cmd_v[i] = '0; wdata_v[i] = '0;
      scnt[i] = 0; ssh[i] = '0; scmd[i] = '0; swa[i] = '0; sra[i] = '0;
      ref_wa[i] = '0; ref_ra[i] = '0; ref_rd[i] = '0;
      for (int j = 0; j < 256; j++) begin
        sram[i][j] = '0; ref_ram[i][j] = '0;
      end
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check("reset_outputs", {ss_n_v[i], mosi_v[i], busy_v[i], done_v[i], rd_valid_v[i], rdata_v[i]},
            {5'b10000, 8'h00});
    rst_v = '0;

    // First start right after reset release, then the write-address example
    run_frame(0, 2'b00, 8'h3C);
    run_frame(0, 2'b00, 8'h05);
    run_frame(0, 2'b01, 8'hA7);
    run_frame(0, 2'b10, 8'h05);
    run_frame(0, 2'b11, 8'h00);
    check("readback_A7", rdata_v[0], 8'hA7);

    // Retention: read 5A, then a write-data frame must not disturb rdata
    run_frame(0, 2'b00, 8'h10);
    run_frame(0, 2'b01, 8'h5A);
    run_frame(0, 2'b10, 8'h10);
    run_frame(0, 2'b11, 8'hFF);
    run_frame(0, 2'b01, 8'h33);
    check("retain_5A", rdata_v[0], 8'h5A);

    // Busy guard: start held high across two frames
    ss_seen = '0; dn_seen = '0; ss_exp = '0; dn_exp = '0;
    start_v[0] = 1'b1; cmd_v[0] = 2'b00; wdata_v[0] = 8'h81;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      ss_seen[k-1] = ss_n_v[0];
      dn_seen[k-1] = done_v[0];
      ss_exp[k-1]  = ((k - 1) % 13) >= 11;
      dn_exp[k-1]  = ((k - 1) % 13) == 11;
      if (k == 26) start_v[0] = 1'b0;
    end
    ref_wa[0] = 8'h81;
    check("guard_ss_pattern", ss_seen, ss_exp);
    check("guard_done_pattern", dn_seen, dn_exp);
    @(negedge clk);
    check("guard_idle", busy_v[0], 0);

    // Reset during RECV bit 4 of a read frame
    run_frame(0, 2'b01, 8'hC3);
    run_frame(0, 2'b10, 8'h81);
    run_frame(0, 2'b11, 8'h00);
    start_v[0] = 1'b1; cmd_v[0] = 2'b11;
    @(posedge clk); #1; start_v[0] = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    rst_v[0] = 1'b1;
    #1;
    check("rst_ss_n", ss_n_v[0], 1);
    check("rst_rdata", rdata_v[0], 8'h00);
    check("rst_busy", busy_v[0], 0);
    ref_rd[0] = 8'h00;
    repeat (2) @(negedge clk);
    rst_v[0] = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    check("no_done_after_abort", ndone, 0);
    run_frame(0, 2'b11, 8'h00);

    // Randomised traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom_range(0, 7));
      v = 8'($urandom);
      case ($urandom_range(0, 2))
        0: begin run_frame(0, 2'b00, a); run_frame(0, 2'b01, v); end
        1: begin run_frame(0, 2'b10, a); run_frame(0, 2'b11, v); end
        default: run_frame(0, 2'($urandom), v);
      endcase
    end

    // RD_WAIT extremes
    for (int d = 1; d < 3; d++) begin
      a = 8'($urandom); v = 8'($urandom);
      run_frame(d, 2'b00, a);
      run_frame(d, 2'b01, v);
      run_frame(d, 2'b10, a);
      run_frame(d, 2'b11, 8'h00);
      check("rdwait_byte", rdata_v[d], v);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
